// File: rtl/bus_datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_datapath_pkg                                                |
// | Brief    : Opcodes, sequencer states and bus-source selects for            |
// |            bus_datapath_seq.                                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package bus_datapath_pkg;

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd3;
    localparam logic [3:0] c_OP_SHL  = 4'd4;
    localparam logic [3:0] c_OP_SHR  = 4'd5;
    localparam logic [3:0] c_OP_MUL  = 4'd6;
    localparam logic [3:0] c_OP_DIV  = 4'd7;
    localparam logic [3:0] c_OP_LDI  = 4'd8;
    localparam logic [3:0] c_OP_MFHI = 4'd9;
    localparam logic [3:0] c_OP_MFLO = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADY = 3'd1,
        S_EXEC  = 3'd2,
        S_ITER  = 3'd3,
        S_WB    = 3'd4,
        S_WBHI  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_RA   = 3'd1,
        BUS_RB   = 3'd2,
        BUS_ZLO  = 3'd3,
        BUS_ZHI  = 3'd4,
        BUS_HI   = 3'd5,
        BUS_LO   = 3'd6
    } bus_sel_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= c_OP_MFLO);
    endfunction

    function automatic logic op_is_md(input logic [3:0] op);
        return (op == c_OP_MUL) || (op == c_OP_DIV);
    endfunction

    // Operations that skip the operand fetch and go straight to write-back.
    function automatic logic op_is_direct(input logic [3:0] op);
        return (op == c_OP_LDI) || (op == c_OP_MFHI) || (op == c_OP_MFLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_unit                                                    |
// | Brief    : One-bit-per-step unsigned shift-add multiplier / restoring      |
// |            divider; the step count is kept by the caller.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div0
);

    // MUL: {r_hi,r_lo} is the running product, r_opnd the multiplicand.
    // DIV: r_hi is the partial remainder, r_lo the dividend/quotient, r_opnd the divisor.
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_div0;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_hi_nxt;

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        if (r_is_div) begin
            // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
            w_hi_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_opnd) : w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Outputs present the post-step value so the caller can capture the final result on the last step edge.
    assign lo   = step ? w_lo_nxt : r_lo;
    assign hi   = step ? w_hi_nxt : r_hi;
    assign div0 = r_div0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
        end else if (start) begin
            r_lo     <= is_div ? a : b;
            r_hi     <= '0;
            r_opnd   <= is_div ? b : a;
            r_is_div <= is_div;
            r_div0   <= is_div && (b == '0);
        end else if (step) begin
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_datapath_seq                                                |
// | Brief    : Single-bus register-file datapath with its own sequencer,       |
// |            ALU, iterative MUL/DIV into HI/LO and debug readback.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bus_datapath_seq
    import bus_datapath_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NREGS  = 16,
    localparam int RIDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [RIDX_W-1:0] ra,
    input  logic [RIDX_W-1:0] rb,
    input  logic [RIDX_W-1:0] rc,
    input  logic [WIDTH-1:0]  in_data,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    input  logic [RIDX_W-1:0] dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int               c_SHAMT_W  = $clog2(WIDTH);
    localparam logic [c_SHAMT_W-1:0] c_CNT_LAST = c_SHAMT_W'(WIDTH - 1);

    state_t              r_state;
    state_t              w_next_state;
    bus_sel_t            w_bus_sel;

    logic [WIDTH-1:0]    r_regs [NREGS];
    logic [WIDTH-1:0]    r_y;
    logic [2*WIDTH-1:0]  r_z;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_result;
    logic                r_done;
    logic                r_err;
    logic                r_zero;
    logic [3:0]          r_op;
    logic [RIDX_W-1:0]   r_ra;
    logic [RIDX_W-1:0]   r_rb;
    logic [RIDX_W-1:0]   r_rc;
    logic [c_SHAMT_W-1:0] r_cnt;

    logic [WIDTH-1:0]    w_bus;
    logic [WIDTH-1:0]    w_alu;
    logic [WIDTH-1:0]    w_md_lo;
    logic [WIDTH-1:0]    w_md_hi;
    logic                w_md_div0;
    logic                w_md_start;
    logic                w_md_step;
    logic                w_xfer;

    assign op_ready = (r_state == S_IDLE);
    assign w_xfer   = op_valid && op_ready;
    assign done     = r_done;
    assign err      = r_err;
    assign result   = r_result;
    assign zero     = r_zero;
    assign dbg_data = r_regs[dbg_sel];

    always_comb begin
        w_bus = '0;
        unique case (w_bus_sel)
            BUS_RA:  w_bus = r_regs[r_ra];
            BUS_RB:  w_bus = r_regs[r_rb];
            BUS_ZLO: w_bus = r_z[WIDTH-1:0];
            BUS_ZHI: w_bus = r_z[2*WIDTH-1:WIDTH];
            BUS_HI:  w_bus = r_hi;
            BUS_LO:  w_bus = r_lo;
            default: w_bus = '0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            c_OP_AND: w_alu = r_y & w_bus;
            c_OP_OR:  w_alu = r_y | w_bus;
            c_OP_ADD: w_alu = r_y + w_bus;
            c_OP_SUB: w_alu = r_y - w_bus;
            c_OP_SHL: w_alu = r_y << w_bus[c_SHAMT_W-1:0];
            c_OP_SHR: w_alu = r_y >> w_bus[c_SHAMT_W-1:0];
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_bus_sel    = BUS_NONE;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer && op_is_legal(op_code)) begin
                    w_next_state = op_is_direct(op_code) ? S_WB : S_LOADY;
                end
            end
            S_LOADY: begin
                w_bus_sel    = BUS_RA;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_bus_sel    = BUS_RB;
                w_next_state = op_is_md(r_op) ? S_ITER : S_WB;
            end
            S_ITER: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                if (r_op == c_OP_MFHI) begin
                    w_bus_sel = BUS_HI;
                end else if (r_op == c_OP_MFLO) begin
                    w_bus_sel = BUS_LO;
                end else begin
                    w_bus_sel = BUS_ZLO;
                end
                w_next_state = op_is_md(r_op) ? S_WBHI : S_IDLE;
            end
            S_WBHI: begin
                w_bus_sel    = BUS_ZHI;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_md_start = (r_state == S_EXEC) && op_is_md(r_op);
    assign w_md_step  = (r_state == S_ITER);

    mul_div_unit #(
        .WIDTH (WIDTH)
    ) u_mul_div (
        .clk    (clk),
        .clr    (clr),
        .start  (w_md_start),
        .step   (w_md_step),
        .is_div (r_op == c_OP_DIV),
        .a      (r_y),
        .b      (w_bus),
        .lo     (w_md_lo),
        .hi     (w_md_hi),
        .div0   (w_md_div0)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_y      <= '0;
            r_z      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_zero   <= 1'b0;
            r_op     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rc     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_op <= op_code;
                        r_ra <= ra;
                        r_rb <= rb;
                        r_rc <= rc;
                        // Illegal opcodes retire immediately and leave result/zero untouched.
                        if (!op_is_legal(op_code)) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (op_code == c_OP_LDI) begin
                            r_z <= {{WIDTH{1'b0}}, in_data};
                        end
                    end
                end
                S_LOADY: r_y <= w_bus;
                S_EXEC: begin
                    r_cnt <= '0;
                    if (!op_is_md(r_op)) begin
                        r_z <= {{WIDTH{1'b0}}, w_alu};
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_z   <= {w_md_hi, w_md_lo};
                end
                S_WB: begin
                    if (op_is_md(r_op)) begin
                        r_lo <= w_bus;
                    end else begin
                        r_regs[r_rc] <= w_bus;
                        r_done       <= 1'b1;
                        r_result     <= w_bus;
                        r_zero       <= (w_bus == '0);
                    end
                end
                S_WBHI: begin
                    r_hi     <= w_bus;
                    r_done   <= 1'b1;
                    r_err    <= (r_op == c_OP_DIV) && w_md_div0;
                    r_result <= r_lo;
                    r_zero   <= (r_lo == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bus_datapath_seq                                             |
// | Brief    : Directed plus randomized bench for bus_datapath_seq against an  |
// |            arithmetic reference model of the register transfers.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bus_datapath_seq;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int RW = $clog2(NR);

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    op_code = '0;
    logic [RW-1:0] ra = '0, rb = '0, rc = '0, dbg_sel = '0;
    logic [W-1:0]  in_data = '0;
    logic          done, err, zero;
    logic [W-1:0]  result, dbg_data;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [W-1:0] m_r [NR];
    logic [W-1:0] m_hi, m_lo, m_result;
    logic         m_zero;

    always #5 clk = ~clk;

    bus_datapath_seq #(.WIDTH(W), .NREGS(NR)) dut (
        .clk      (clk),
        .clr      (clr),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .in_data  (in_data),
        .done     (done),
        .err      (err),
        .result   (result),
        .zero     (zero),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = '0;
        m_hi = '0; m_lo = '0; m_result = '0; m_zero = 1'b0;
    endtask

    task automatic check_reg(input int idx, input string tag);
        dbg_sel = RW'(idx);
        #1;
        check(tag, dbg_data, m_r[idx]);
    endtask

    // Apply one operation to the model; returns expected err and done latency
    // (edges after the transfer edge up to the edge that raises done).
    task automatic model_op(input logic [3:0] op, input int a, input int b, input int c,
                            input logic [W-1:0] d, output logic e_err, output int e_lat);
        logic [W-1:0]   va, vb, wv;
        logic [2*W-1:0] p;
        logic           wr;
        va = m_r[a]; vb = m_r[b]; e_err = 1'b0; wr = 1'b1; wv = '0;
        e_lat = 3;
        case (op)
            4'd0: wv = va & vb;
            4'd1: wv = va | vb;
            4'd2: wv = va + vb;
            4'd3: wv = va - vb;
            4'd4: wv = va << (vb % W);
            4'd5: wv = va >> (vb % W);
            4'd6: begin
                p = {{W{1'b0}}, va} * {{W{1'b0}}, vb};
                m_lo = p[W-1:0]; m_hi = p[2*W-1:W];
                wr = 1'b0; e_lat = W + 4;
            end
            4'd7: begin
                if (vb == '0) begin
                    m_lo = '1; m_hi = va; e_err = 1'b1;
                end else begin
                    m_lo = va / vb; m_hi = va % vb;
                end
                wr = 1'b0; e_lat = W + 4;
            end
            4'd8:  begin wv = d;    e_lat = 1; end
            4'd9:  begin wv = m_hi; e_lat = 1; end
            4'd10: begin wv = m_lo; e_lat = 1; end
            default: begin wr = 1'b0; e_err = 1'b1; e_lat = 0; end
        endcase
        if (op <= 4'd10) begin
            if (wr) begin
                m_r[c] = wv; m_result = wv;
            end else begin
                m_result = m_lo;
            end
            m_zero = (m_result == '0);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input int a, input int b, input int c,
                         input logic [W-1:0] d, input string tag);
        logic e_err;
        int   e_lat, lat;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1; op_code = op; ra = RW'(a); rb = RW'(b); rc = RW'(c); in_data = d;
        model_op(op, a, b, c, d, e_err, e_lat);
        @(posedge clk);
        #1;
        // Scramble inputs after transfer; they must be ignored.
        op_valid = 1'b0; op_code = 4'($urandom); ra = RW'($urandom); rb = RW'($urandom);
        rc = RW'($urandom); in_data = $urandom;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"},    lat, e_lat);
        check({tag, "_err"},    {31'd0, err}, {31'd0, e_err});
        check({tag, "_result"}, result, m_result);
        check({tag, "_zero"},   {31'd0, zero}, {31'd0, m_zero});
        if (op <= 4'd10) check_reg(c, {tag, "_rc"});
    endtask

    initial begin
        int seen;
        logic [3:0] op;
        model_reset();
        #23;
        check("rst_ready",  {31'd0, op_ready}, 32'd1);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, '0);
        @(negedge clk);
        clr = 1'b1;
        check_reg(7, "rst_r7");

        // Logic
        do_op(4'd8, 0, 0, 1, 32'h0000_00F0, "ldi_r1");
        do_op(4'd8, 0, 0, 2, 32'h0000_0F0F, "ldi_r2");
        do_op(4'd0, 1, 2, 3, '0, "and");
        do_op(4'd1, 1, 2, 14, '0, "or");
        // Wraparound and shift amount truncation
        do_op(4'd8, 0, 0, 4, 32'hFFFF_FFFF, "ldi_r4");
        do_op(4'd8, 0, 0, 5, 32'h0000_0001, "ldi_r5");
        do_op(4'd2, 4, 5, 6, '0, "add_wrap");
        do_op(4'd3, 0, 5, 7, '0, "sub_wrap");
        do_op(4'd8, 0, 0, 8, 32'd33, "ldi_r8");
        do_op(4'd4, 5, 8, 9, '0, "shl33");
        do_op(4'd5, 4, 8, 15, '0, "shr33");
        // MUL into HI/LO
        do_op(4'd6, 4, 4, 0, '0, "mul_max");
        do_op(4'd9, 0, 0, 5, '0, "mfhi");
        do_op(4'd10, 0, 0, 10, '0, "mflo");
        // DIV, including divide by zero
        do_op(4'd8, 0, 0, 11, 32'd100, "ldi_r11");
        do_op(4'd8, 0, 0, 12, 32'd7, "ldi_r12");
        do_op(4'd7, 11, 12, 0, '0, "div_100_7");
        do_op(4'd9, 0, 0, 13, '0, "mfhi_div");
        do_op(4'd8, 0, 0, 13, 32'd5, "ldi_r13");
        do_op(4'd8, 0, 0, 0, 32'd0, "ldi_r0");
        do_op(4'd7, 13, 0, 0, '0, "div_by0");
        do_op(4'd9, 0, 0, 12, '0, "mfhi_div0");
        // Illegal then immediate back-to-back transfer
        do_op(4'd15, 1, 2, 3, '0, "illegal");
        do_op(4'd2, 3, 3, 3, '0, "b2b_add_same");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 13);
            if (k >= 11) op = (k == 13) ? 4'd8 : 4'($urandom_range(11, 15));
            else op = 4'(k);
            do_op(op, $urandom_range(0, NR-1), $urandom_range(0, NR-1), $urandom_range(0, NR-1),
                  $urandom, "rand");
        end
        for (int i = 0; i < NR; i++) check_reg(i, "dump");

        // Reset in the middle of a MUL
        do_op(4'd8, 0, 0, 4, 32'h1234_5678, "ldi_pre");
        @(negedge clk);
        op_valid = 1'b1; op_code = 4'd6; ra = 4'd4; rb = 4'd4; rc = 4'd0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2 clr = 1'b0;
        model_reset();
        #1;
        check("midrst_ready", {31'd0, op_ready}, 32'd1);
        check_reg(4, "midrst_r4");
        @(negedge clk);
        clr = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midrst_nodone", seen, 0);
        check("midrst_result", result, '0);
        do_op(4'd9, 0, 0, 1, '0, "midrst_hi");
        do_op(4'd10, 0, 0, 2, '0, "midrst_lo");
        for (int i = 0; i < NR; i++) check_reg(i, "midrst_dump");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
